// File: rtl/toeplitz_gen.sv
// rtl/toeplitz_gen.sv - Toeplitz/Hankel matrix streamer fed from a single vector fetch
//
// Fetches the generating vector v[0..N-1] (N = ROW+COL-1) once from a
// synchronous-read memory into a local buffer. It then streams the ROW x COL
// matrix over a valid/ready handshake.
//   Toeplitz (mode=0): M[r][c] = v[c-r+ROW-1]
//   Hankel   (mode=1): M[r][c] = v[r+c]
//
// Optional feature macro: TOEPLITZ_COLMAJOR_EN adds input col_major, which
// selects column-major streaming order.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   start, mode           job request (sampled in IDLE), Toeplitz/Hankel select
//   base_addr             address of v[0], latched with start
//   col_major             (TOEPLITZ_COLMAJOR_EN only) column-major order, latched with start
//   rd, addr, data        memory read strobe/address; data is valid one cycle after rd
//   busy, done            job in flight; one-cycle completion pulse
//   out_valid/out_ready   element handshake
//   out_data/out_row/out_col/out_last  element value, indices, final-element flag
module toeplitz_gen #(
    parameter int ROW   = 4,
    parameter int COL   = 4,
    parameter int WIDTH = 16,
    parameter int ADDR  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     mode,
    input  logic [ADDR-1:0]          base_addr,
`ifdef TOEPLITZ_COLMAJOR_EN
    input  logic                     col_major,
`endif
    output logic                     rd,
    output logic [ADDR-1:0]          addr,
    input  logic [WIDTH-1:0]         data,
    output logic                     busy,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [$clog2(ROW):0]     out_row,
    output logic [$clog2(COL):0]     out_col,
    output logic                     out_last,
    output logic                     done
);
    localparam int N   = ROW + COL - 1;
    localparam int CW  = $clog2(N) + 1;
    localparam int RW  = $clog2(ROW) + 1;
    localparam int CLW = $clog2(COL) + 1;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_STREAM, S_DONE} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_mode;
    logic [ADDR-1:0]    r_base;
    logic [CW-1:0]      r_cnt;
    logic               r_wr_en;
    logic [CW-1:0]      r_wr_idx;
    logic [WIDTH-1:0]   r_vbuf [N];
    logic [RW-1:0]      r_row;
    logic [CLW-1:0]     r_col;
    logic [WIDTH-1:0]   r_data;
    logic               r_valid;
    logic               r_last;
    logic               r_colmaj;

    logic               w_colmaj;
    logic               w_fire;
    logic [RW-1:0]      w_nrow;
    logic [CLW-1:0]     w_ncol;
    logic [RW-1:0]      w_ld_row;
    logic [CLW-1:0]     w_ld_col;
    logic [CW-1:0]      w_idx;
    logic [WIDTH-1:0]   w_elem;

`ifdef TOEPLITZ_COLMAJOR_EN
    assign w_colmaj = r_colmaj;
`else
    assign w_colmaj = 1'b0;
`endif

    assign w_fire    = r_valid && out_ready;
    assign rd        = (r_state == S_FETCH) && (r_cnt < CW'(N));
    assign addr      = rd ? (r_base + ADDR'(r_cnt)) : '0;
    assign busy      = (r_state == S_FETCH) || (r_state == S_STREAM);
    assign done      = (r_state == S_DONE);
    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign out_row   = r_row;
    assign out_col   = r_col;
    assign out_last  = r_last;

    // Successor of the current element in the selected scan order.
    always_comb begin
        w_nrow = r_row;
        w_ncol = r_col;
        if (w_colmaj) begin
            if (r_row == RW'(ROW - 1)) begin
                w_nrow = '0;
                w_ncol = r_col + 1'b1;
            end else begin
                w_nrow = r_row + 1'b1;
            end
        end else begin
            if (r_col == CLW'(COL - 1)) begin
                w_ncol = '0;
                w_nrow = r_row + 1'b1;
            end else begin
                w_ncol = r_col + 1'b1;
            end
        end
    end

    // The element being loaded is (0,0) on FETCH exit, otherwise the successor.
    // Toeplitz index is formed as c+(ROW-1)-r so it never goes negative.
    always_comb begin
        w_ld_row = (r_state == S_FETCH) ? '0 : w_nrow;
        w_ld_col = (r_state == S_FETCH) ? '0 : w_ncol;
        if (r_mode)
            w_idx = CW'(w_ld_row) + CW'(w_ld_col);
        else
            w_idx = CW'(w_ld_col) + CW'(ROW - 1) - CW'(w_ld_row);
        w_elem = '0;
        for (int i = 0; i < N; i++) begin
            if (w_idx == CW'(i))
                w_elem = r_vbuf[i];
        end
        // v[N-1] is still on the memory data bus when FETCH exits (COL=1 case).
        if (r_wr_en && (r_wr_idx == w_idx))
            w_elem = data;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (start) w_state_nxt = S_FETCH;
            S_FETCH:  if (r_cnt == CW'(N)) w_state_nxt = S_STREAM;
            S_STREAM: if (w_fire && r_last) w_state_nxt = S_DONE;
            S_DONE:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_mode   <= 1'b0;
            r_base   <= '0;
            r_cnt    <= '0;
            r_wr_en  <= 1'b0;
            r_wr_idx <= '0;
            r_row    <= '0;
            r_col    <= '0;
            r_data   <= '0;
            r_valid  <= 1'b0;
            r_last   <= 1'b0;
            r_colmaj <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            // Read data returns one cycle after rd, so the write index trails the read index.
            r_wr_en  <= rd;
            r_wr_idx <= r_cnt;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mode <= mode;
                        r_base <= base_addr;
                        r_cnt  <= '0;
`ifdef TOEPLITZ_COLMAJOR_EN
                        r_colmaj <= col_major;
`endif
                    end
                end
                S_FETCH: begin
                    if (r_cnt == CW'(N)) begin
                        r_row   <= '0;
                        r_col   <= '0;
                        r_data  <= w_elem;
                        r_valid <= 1'b1;
                        r_last  <= (ROW == 1) && (COL == 1);
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_STREAM: begin
                    if (w_fire) begin
                        if (r_last) begin
                            r_valid <= 1'b0;
                            r_last  <= 1'b0;
                        end else begin
                            r_row  <= w_nrow;
                            r_col  <= w_ncol;
                            r_data <= w_elem;
                            r_last <= (w_nrow == RW'(ROW - 1)) && (w_ncol == CLW'(COL - 1));
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (r_wr_en && (r_wr_idx == CW'(i)))
                r_vbuf[i] <= data;
        end
    end
endmodule

// File: tb/tb_toeplitz_gen.sv
// tb/tb_toeplitz_gen.sv - self-checking bench for toeplitz_gen (4x4 instance and 2x5 instance)
module tb_toeplitz_gen;
    localparam int RA = 4, CA = 4, NA = RA + CA - 1;
    localparam int RB = 2, CB = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start, mode, cmaj;
    logic [7:0]  base;
    logic        rd;
    logic [7:0]  addr;
    logic [15:0] data;
    logic        busy, out_valid, out_ready, out_last, done;
    logic [15:0] out_data;
    logic [2:0]  out_row, out_col;

    logic        start_b, mode_b, rd_b, busy_b, valid_b, ready_b, last_b, done_b;
    logic [7:0]  base_b, addr_b;
    logic [15:0] data_b, dout_b;
    logic [1:0]  row_b;
    logic [3:0]  col_b;

    logic [15:0] mem [256];
    always @(posedge clk) begin
        if (rd)   data   <= mem[addr];
        if (rd_b) data_b <= mem[addr_b];
    end

    toeplitz_gen #(.ROW(RA), .COL(CA), .WIDTH(16), .ADDR(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .base_addr(base),
`ifdef TOEPLITZ_COLMAJOR_EN
        .col_major(cmaj),
`endif
        .rd(rd), .addr(addr), .data(data), .busy(busy),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_row(out_row), .out_col(out_col), .out_last(out_last), .done(done)
    );

    toeplitz_gen #(.ROW(RB), .COL(CB), .WIDTH(16), .ADDR(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .mode(mode_b), .base_addr(base_b),
`ifdef TOEPLITZ_COLMAJOR_EN
        .col_major(1'b0),
`endif
        .rd(rd_b), .addr(addr_b), .data(data_b), .busy(busy_b),
        .out_valid(valid_b), .out_ready(ready_b), .out_data(dout_b),
        .out_row(row_b), .out_col(col_b), .out_last(last_b), .done(done_b)
    );

    int total = 0, bad = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, got, want, $time);
        end
    endtask

    // Behavioural model: a job is the list of matrix elements in scan order,
    // built at acceptance from the mapping rules; timing follows the fixed
    // fetch length (rd in cycles 0..N-1 after acceptance, first element at N+1).
    bit          active = 0, done_due = 0, m_idle, seen_v;
    int          k, rd_cnt, lat, mr, mc, mix;
    logic [7:0]  m_base;
    logic [15:0] eq[$];
    int          rq[$], cq[$];
    logic [15:0] cap [RA][CA];

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_outs", {rd, addr, busy, out_valid, out_data, out_row, out_col, out_last, done}, 64'd0);
            active = 0; done_due = 0;
            eq.delete(); rq.delete(); cq.delete();
        end else begin
            m_idle = !active && !done_due;
            chk("busy", busy, active);
            chk("done", done, done_due);
            done_due = 0;
            if (active) begin
                chk("rd", rd, k < NA);
                if (k < NA) chk("addr", addr, 8'(m_base + k));
                if (rd) rd_cnt++;
                if (k >= NA + 1) begin
                    chk("out_valid", out_valid, 1);
                    if (!seen_v && out_valid) begin lat = k + 1; seen_v = 1; end
                    chk("out_data", out_data, eq[0]);
                    chk("out_rc", {out_row, out_col}, {3'(rq[0]), 3'(cq[0])});
                    chk("out_last", out_last, eq.size() == 1);
                    if (out_ready) begin
                        cap[rq[0]][cq[0]] = out_data;
                        void'(eq.pop_front()); void'(rq.pop_front()); void'(cq.pop_front());
                        if (eq.size() == 0) begin active = 0; done_due = 1; end
                    end
                end else begin
                    chk("out_valid", out_valid, 0);
                end
                k++;
            end else begin
                chk("idle_rd", rd, 0);
                chk("idle_valid", out_valid, 0);
                if (m_idle && start) begin
                    active = 1; k = 0; m_base = base; rd_cnt = 0; seen_v = 0;
                    for (int o = 0; o < RA * CA; o++) begin
                        mr = o / CA; mc = o % CA;
`ifdef TOEPLITZ_COLMAJOR_EN
                        if (cmaj) begin mr = o % RA; mc = o / RA; end
`endif
                        mix = mode ? (mr + mc) : (mc - mr + RA - 1);
                        eq.push_back(mem[8'(base + mix)]);
                        rq.push_back(mr); cq.push_back(mc);
                    end
                end
            end
        end
    end

    logic [7:0]  qa_b[$];
    logic [15:0] qv_b[$];
    logic        ql_b[$];
    int          nd_b = 0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (rd_b) qa_b.push_back(addr_b);
            if (valid_b && ready_b) begin qv_b.push_back(dout_b); ql_b.push_back(last_b); end
            if (done_b) nd_b++;
        end
    end

    task automatic init_dir();
        for (int a = 0; a < 256; a++) mem[a] = 16'h100 + 16'(8'(a - 'h10));
    endtask

    task automatic job_a(input logic m, input logic [7:0] b, input int pct,
                         input bit hold, input bit spur, input bit rst_mid);
        bit held = 0, fin = 0;
        @(posedge clk); #1;
        start = 1; mode = m; base = b;
        @(posedge clk); #1;
        start = 0; mode = ~m; base = ~b;
        for (int t = 0; t < 400 && !fin; t++) begin
            start = spur && (t == 2);
            if (hold && !held && out_valid && out_row == 3'd1 && out_col == 3'd1) begin
                held = 1; out_ready = 0;
                repeat (5) begin
                    chk("hold_data", out_data, 16'h103);
                    chk("hold_rc", {out_row, out_col}, 6'o11);
                    chk("hold_valid", out_valid, 1);
                    @(posedge clk); #1;
                end
            end
            if (rst_mid && out_valid && out_row == 3'd1 && out_col == 3'd2) begin
                rst_n = 0; #1;
                chk("rst_mid_outs", {rd, addr, busy, out_valid, out_data, out_row, out_col, out_last, done}, 64'd0);
                @(posedge clk); #1;
                rst_n = 1;
                fin = 1;
            end else begin
                out_ready = ($urandom_range(99) < pct);
                @(posedge clk); #1;
                if (done) fin = 1;
            end
        end
        if (!fin) chk("job_timeout", 0, 1);
        start = 0; out_ready = 0;
    endtask

    task automatic job_b();
        bit fin = 0;
        qa_b.delete(); qv_b.delete(); ql_b.delete(); nd_b = 0;
        @(posedge clk); #1;
        start_b = 1; mode_b = 0; base_b = 8'hFE; ready_b = 1;
        @(posedge clk); #1;
        start_b = 0; base_b = 8'h00;
        for (int t = 0; t < 100 && !fin; t++) begin
            @(posedge clk); #1;
            if (done_b) fin = 1;
        end
        if (!fin) chk("b_timeout", 0, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("b_addr_n", qa_b.size(), 6);
        for (int i = 0; i < 6 && i < qa_b.size(); i++) chk("b_addr", qa_b[i], 8'(8'hFE + i));
        chk("b_elems_n", qv_b.size(), RB * CB);
        for (int i = 0; i < RB * CB && i < qv_b.size(); i++) begin
            chk("b_elem", qv_b[i], mem[8'(8'hFE + (i % CB) - (i / CB) + RB - 1)]);
            chk("b_last", ql_b[i], i == RB * CB - 1);
        end
        if (qv_b.size() > 5) chk("b_m10", qv_b[5], 16'h1EE);
        chk("b_done_n", nd_b, 1);
    endtask

    initial begin
        rst_n = 0; start = 0; mode = 0; base = 0; out_ready = 0; cmaj = 0;
        start_b = 0; mode_b = 0; base_b = 0; ready_b = 0;
        init_dir();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_last", out_last, 0);
        rst_n = 1;

        job_a(0, 8'h10, 100, 0, 0, 0);
        chk("latency", lat, 9);
        chk("rd_cycles", rd_cnt, 7);
        for (int c = 0; c < CA; c++) begin
            chk("t_row0", cap[0][c], 16'h103 + c);
            chk("t_row1", cap[1][c], 16'h102 + c);
            chk("t_row3", cap[3][c], 16'h100 + c);
        end

        job_a(1, 8'h10, 100, 0, 0, 0);
        for (int c = 0; c < CA; c++) begin
            chk("h_row0", cap[0][c], 16'h100 + c);
            chk("h_row3", cap[3][c], 16'h103 + c);
        end

        job_a(0, 8'h10, 100, 1, 0, 0);
        chk("after_hold_12", cap[1][2], 16'h104);

        job_a(0, 8'h10, 100, 0, 1, 0);
        job_a(0, 8'h10, 100, 0, 0, 1);
        job_a(1, 8'h10, 60, 0, 0, 0);

`ifdef TOEPLITZ_COLMAJOR_EN
        cmaj = 1;
        job_a(0, 8'h10, 100, 0, 0, 0);
        for (int r = 0; r < RA; r++) chk("cm_col0", cap[r][0], 16'h103 - r);
        cmaj = 0;
`endif

        job_b();

        for (int j = 0; j < 20; j++) begin
            for (int a = 0; a < 256; a++) mem[a] = 16'($urandom);
            job_a(1'($urandom), 8'($urandom), $urandom_range(30, 100), 0, j % 4 == 1, 0);
        end

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
